// File: rtl/picorv_dma_pkg.sv
// Shared constants for the picorv stream DMA: FSM state encodings, transfer
// direction codes and bus word constants.
package picorv_dma_pkg;

  // FSM state encodings
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WREQ  = 3'd2;
  localparam logic [2:0] RREQ  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // Transfer direction as presented on the mode input
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WSTRB_FULL = 4'hF;

endpackage

// File: rtl/picorv_dma_addr_gen.sv
// Address register and remaining-word counter for the picorv stream DMA.
// The address and the count step independently because in read mode the
// address advances on the bus completion while the count drops on the push.
module picorv_dma_addr_gen
  import picorv_dma_pkg::*;
#(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [31:0]         base_addr,
  input  logic [CNT_BITS-1:0] word_count,
  input  logic                step_addr,
  input  logic                step_count,
  output logic [31:0]         addr,
  output logic                last
);

  logic [CNT_BITS-1:0] remaining_q;

  // Word-aligned address; wraps modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= 32'h0;
    end else if (load) begin
      addr <= base_addr & 32'hFFFF_FFFC;
    end else if (step_addr) begin
      addr <= addr + WORD_BYTES;
    end
  end

  // Words still to be moved, including the one in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
    end else if (load) begin
      remaining_q <= word_count;
    end else if (step_count) begin
      remaining_q <= remaining_q - 1'b1;
    end
  end

  // Current word is the final one of the command
  assign last = (remaining_q <= CNT_BITS'(1));

endmodule

// File: rtl/picorv_stream_dma.sv
// picorv native-bus initiator moving words between a 32-bit val/ready stream
// and consecutive memory words (mode 0: stream->memory, mode 1: memory->stream).
// Optional build macro PICORV_DMA_TIMEOUT_EN adds a per-request ready timeout
// that sets the sticky error flag and abandons the command.
module picorv_stream_dma
  import picorv_dma_pkg::*;
#(
  parameter int unsigned CNT_BITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [31:0]         base_addr,
  input  logic [CNT_BITS-1:0] word_count,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata,
  input  logic [31:0]         din,
  input  logic                val_in,
  output logic                ready_upward,
  output logic [31:0]         dout,
  output logic                val_out,
  input  logic                ready_downward
);

  logic [2:0] state_q, state_d;
  logic       in_req, load, step_addr, step_count, last, tmo_fire;

  assign in_req     = (state_q == WREQ) || (state_q == RREQ);
  assign load       = (state_q == IDLE) && start;
  assign step_addr  = in_req && mem_ready;
  assign step_count = ((state_q == WREQ) && mem_ready) || ((state_q == PUSH) && ready_downward);

  picorv_dma_addr_gen #(
    .CNT_BITS(CNT_BITS)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .base_addr (base_addr),
    .word_count(word_count),
    .step_addr (step_addr),
    .step_count(step_count),
    .addr      (mem_addr),
    .last      (last)
  );

  // Next-state decode; a ready in the same cycle as a timeout wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0)        state_d = DONE;
          else if (mode == MODE_READ)  state_d = RREQ;
          else                         state_d = FETCH;
        end
      end
      FETCH: if (val_in) state_d = WREQ;
      WREQ: begin
        if (mem_ready)     state_d = last ? DONE : FETCH;
        else if (tmo_fire) state_d = DONE;
      end
      RREQ: begin
        if (mem_ready)     state_d = PUSH;
        else if (tmo_fire) state_d = DONE;
      end
      PUSH: if (ready_downward) state_d = last ? DONE : RREQ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Write data captured from the stream, held through the bus request
  always_ff @(posedge clk) begin
    if (reset)                              mem_wdata <= 32'h0;
    else if ((state_q == FETCH) && val_in)  mem_wdata <= din;
  end

  // Read data captured from the bus, held until the downstream push
  always_ff @(posedge clk) begin
    if (reset)                                 dout <= 32'h0;
    else if ((state_q == RREQ) && mem_ready)   dout <= mem_rdata;
  end

  assign busy         = (state_q == FETCH) || in_req || (state_q == PUSH);
  assign done         = (state_q == DONE);
  assign mem_valid    = in_req;
  assign mem_instr    = 1'b0;
  assign mem_wstrb    = (state_q == WREQ) ? WSTRB_FULL : 4'h0;
  assign ready_upward = (state_q == FETCH);
  assign val_out      = (state_q == PUSH);

`ifdef PICORV_DMA_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  // Cycles the current request has waited; idles at zero between requests
  always_ff @(posedge clk) begin
    if (reset || !in_req)  tmo_q <= '0;
    else if (!mem_ready)   tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_fire = in_req && !mem_ready && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared by the next accepted command
  always_ff @(posedge clk) begin
    if (reset || load) error <= 1'b0;
    else if (tmo_fire) error <= 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_picorv_stream_dma.sv
// Scoreboard bench for picorv_stream_dma: commands push expected bus writes,
// read addresses and stream words into queues; a monitor pops and compares.
// Timeout checks are built only when PICORV_DMA_TIMEOUT_EN is defined.
module tb_picorv_stream_dma;

  localparam int unsigned CNT_BITS = 16;
  localparam int unsigned TMO      = 16;

  logic                clk = 1'b0;
  logic                reset, start, mode;
  logic [31:0]         base_addr;
  logic [CNT_BITS-1:0] word_count;
  logic                busy, done, error;
  logic                mem_valid, mem_instr, mem_ready;
  logic [31:0]         mem_addr, mem_wdata, mem_rdata;
  logic [3:0]          mem_wstrb;
  logic [31:0]         din, dout;
  logic                val_in, ready_upward, val_out, ready_downward;

  always #5 clk = ~clk;

  picorv_stream_dma #(
    .CNT_BITS      (CNT_BITS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .din           (din),
    .val_in        (val_in),
    .ready_upward  (ready_upward),
    .dout          (dout),
    .val_out       (val_out),
    .ready_downward(ready_downward)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  // Memory model; untouched words read back as a function of their address
  logic [31:0] mem_m [logic [31:0]];
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] src_q [$];
  logic [63:0] exp_wr[$];
  logic [31:0] exp_ra[$];
  logic [31:0] exp_rd[$];

  int resp_delay = 0;
  bit src_gap    = 1'b0;
  bit sink_rand  = 1'b0;
  int sink_hold  = 0;
  int done_cnt   = 0;
  int mv_cycles  = 0;

  // Responder: ready pulse after resp_delay wait cycles; checks request stability
  initial begin
    int cnt;
    logic [31:0] a0, w0;
    cnt = 0; a0 = '0; w0 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
        chk("valid_after_ready", 64'(mem_valid), 64'(0));
      end else if (mem_valid && !reset) begin
        if (cnt == 0) begin
          a0 = mem_addr; w0 = mem_wdata;
        end else begin
          chk("addr_stable", 64'(mem_addr), 64'(a0));
          chk("wdata_stable", 64'(mem_wdata), 64'(w0));
        end
        if (cnt >= resp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_read(mem_addr);
          if (mem_wstrb == 4'hF) mem_m[mem_addr] = mem_wdata;
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Upstream source: presents queued words, optionally with random gaps
  initial begin
    val_in = 1'b0; din = '0;
    forever begin
      @(negedge clk);
      if (src_q.size() != 0 && (val_in || !src_gap || $urandom_range(0, 3) != 0)) begin
        val_in = 1'b1; din = src_q[0];
      end else begin
        val_in = 1'b0;
      end
      #4;
      if (val_in && ready_upward && src_q.size() != 0) void'(src_q.pop_front());
    end
  end

  // Downstream sink: optional forced stall, then always-ready or random
  initial begin
    ready_downward = 1'b0;
    forever begin
      @(negedge clk);
      if (val_out && sink_hold > 0) begin
        ready_downward = 1'b0;
        sink_hold--;
      end else begin
        ready_downward = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops scoreboard entries on every handshake
  initial begin
    bit pd, pv, pr, pacc, prd;
    logic [31:0] pdout;
    logic [63:0] e;
    {pd, pv, pr, pacc, prd} = '0;
    pdout = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        {pd, pv, pr, pacc, prd} = '0;
      end else begin
        if (mem_valid) mv_cycles++;
        if (pacc) chk("wr_latency", 64'(mem_valid), 64'(1));
        if (prd)  chk("rd_latency", 64'(val_out), 64'(1));
        if (pv && !pr) begin
          chk("val_out_held", 64'(val_out), 64'(1));
          chk("dout_held", 64'(dout), 64'(pdout));
        end
        if (mem_valid && mem_ready) begin
          chk("mem_instr", 64'(mem_instr), 64'(0));
          if (mem_wstrb == 4'hF) begin
            chk("write_expected", 64'(exp_wr.size() != 0), 64'(1));
            if (exp_wr.size() != 0) begin
              e = exp_wr.pop_front();
              chk("write", {mem_addr, mem_wdata}, e);
            end
          end else begin
            chk("read_wstrb", 64'(mem_wstrb), 64'(0));
            chk("read_expected", 64'(exp_ra.size() != 0), 64'(1));
            if (exp_ra.size() != 0) chk("read_addr", 64'(mem_addr), 64'(exp_ra.pop_front()));
          end
        end
        if (val_out && ready_downward) begin
          chk("no_overlap", 64'(mem_valid), 64'(0));
          chk("push_expected", 64'(exp_rd.size() != 0), 64'(1));
          if (exp_rd.size() != 0) chk("push_data", 64'(dout), 64'(exp_rd.pop_front()));
        end
        if (done) begin
          done_cnt++;
          chk("done_single", 64'(pd), 64'(0));
          chk("done_not_busy", 64'(busy), 64'(0));
        end
        pacc  = val_in && ready_upward;
        prd   = mem_valid && mem_ready && (mem_wstrb == 4'h0);
        pv    = val_out;
        pr    = ready_downward;
        pdout = dout;
        pd    = done;
      end
    end
  end

  // One command: build expectations from the address rule, issue, await done
  task automatic run_cmd(input logic md, input logic [31:0] base, input int cnt,
                         input int dly, input int glitch, input bit fixed);
    logic [31:0] a, d;
    int d0, mv0, k;
    bit got;
    a = base & 32'hFFFF_FFFC;
    resp_delay = dly;
    for (int i = 0; i < cnt; i++) begin
      if (md == 1'b0) begin
        d = fixed ? 32'hA + 32'(i) : $urandom;
        src_q.push_back(d);
        exp_wr.push_back({a, d});
      end else begin
        exp_ra.push_back(a);
        exp_rd.push_back(mem_read(a));
      end
      a = a + 32'd4;
    end
    d0 = done_cnt; mv0 = mv_cycles;
    @(negedge clk);
    mode = md; base_addr = base; word_count = CNT_BITS'(cnt); start = 1'b1;
    got = 1'b0;
    k = 0;
    while (k < 400 && !got) begin
      @(negedge clk);
      if (k == glitch) begin
        start = 1'b1; mode = ~md; base_addr = 32'h999; word_count = 5;
      end else begin
        start = 1'b0;
      end
      #3;
      if (k == 0) chk("busy_after_start", 64'(busy), 64'(cnt != 0));
      if (done_cnt != d0) got = 1'b1;
      else k++;
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'(1));
    if (cnt == 0) begin
      chk("zero_done_latency", 64'(k <= 1), 64'(1));
      chk("zero_no_valid", 64'(mv_cycles - mv0), 64'(0));
    end
    @(negedge clk);
    #3;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_valid", 64'(mem_valid), 64'(0));
    chk("sb_empty", 64'(exp_wr.size() + exp_ra.size() + exp_rd.size() + src_q.size()), 64'(0));
  endtask

  initial begin
    int k, d0, mv0;
    bit got;
    reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_ctrl", 64'({busy, done, error, mem_valid, mem_wstrb, ready_upward, val_out}), 64'(0));
    chk("reset_bus", {mem_addr, mem_wdata}, 64'(0));
    chk("reset_dout", 64'(dout), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios
    run_cmd(1'b0, 32'h100, 3, 0, -1, 1'b1);
    mem_m[32'h200] = 32'h11;
    mem_m[32'h204] = 32'h22;
    sink_hold = 5;
    run_cmd(1'b1, 32'h200, 2, 0, -1, 1'b0);
    chk("sink_stall_used", 64'(sink_hold), 64'(0));
    run_cmd(1'b0, 32'h40, 0, 0, -1, 1'b0);
    run_cmd(1'b0, 32'h300, 2, 7, 3, 1'b0);
    run_cmd(1'b0, 32'hFFFF_FFFE, 2, 0, -1, 1'b0);
    run_cmd(1'b1, 32'hFFFF_FFFC, 2, 1, -1, 1'b0);

    // Randomized commands
    src_gap = 1'b1; sink_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 6),
              $urandom_range(0, 3), -1, 1'b0);
    end
    src_gap = 1'b0; sink_rand = 1'b0;

    // Reset while a write request is waiting
    resp_delay = 1000;
    src_q.push_back(32'h1234);
    src_q.push_back(32'h5678);
    @(negedge clk);
    mode = 1'b0; base_addr = 32'h500; word_count = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      #3;
      if (mem_valid) got = 1'b1;
    end
    chk("wreq_reached", 64'(got), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    src_q.delete();
    @(negedge clk);
    #3;
    chk("reset_mid_ctrl", 64'({busy, done, error, mem_valid, mem_wstrb, ready_upward, val_out}),
        64'(0));
    chk("reset_mid_bus", {mem_addr, mem_wdata}, 64'(0));
    chk("reset_mid_dout", 64'(dout), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    resp_delay = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("post_reset_idle", 64'({busy, mem_valid, ready_upward}), 64'(0));

`ifdef PICORV_DMA_TIMEOUT_EN
    // Silent responder: request abandoned after TMO cycles
    resp_delay = 1000;
    src_q.push_back(32'hDEAD_BEEF);
    d0 = done_cnt; mv0 = mv_cycles;
    @(negedge clk);
    mode = 1'b0; base_addr = 32'h600; word_count = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      #3;
      if (done_cnt != d0) got = 1'b1;
    end
    chk("tmo_done", 64'(got), 64'(1));
    chk("tmo_valid_cycles", 64'(mv_cycles - mv0), 64'(TMO));
    chk("tmo_error", 64'(error), 64'(1));
    src_q.delete();
    resp_delay = 0;
    @(negedge clk);
    #3;
    chk("tmo_error_sticky", 64'(error), 64'(1));
    run_cmd(1'b0, 32'h700, 0, 0, -1, 1'b0);
    chk("tmo_error_cleared", 64'(error), 64'(0));
`else
    d0 = 0; mv0 = 0;
    chk("error_tied_low", 64'(error), 64'(d0 + mv0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
